// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte output.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   rx         asynchronous serial line, idle high, LSB first
//   rx_data    last accepted byte
//   rx_valid   rx_data holds a byte the consumer has not taken yet
//   rx_ready   consumer strobe
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky: a good byte was dropped because rx_valid was still high
//   busy       receiver is not idle
//   fsm_state  current receiver state, for observation only
//
// Handshake: a byte moves to the consumer on every rising edge where
// rx_valid && rx_ready are both high. rx_valid then falls on the next cycle,
// unless a new byte is accepted on that same edge, in which case the new byte
// replaces the consumed one and rx_valid stays high. rx_ready while rx_valid
// is low is ignored.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  logic        rx_m;
  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;

  logic bit_end;
  logic accept;
  logic bad_stop;

  assign bit_end  = (cnt == LAST_CLK);
  assign accept   = (state == ST_STOP) && bit_end && rx_s;
  assign bad_stop = (state == ST_STOP) && bit_end && !rx_s;

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      frame_err <= bad_stop;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= 16'd0;
          end
        end

        // Re-check the line at the middle of the start bit so a short
        // glitch is rejected; this also centres all later samples.
        ST_START: begin
          if (cnt == HALF_BIT) begin
            cnt <= 16'd0;
            idx <= 3'd0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            shreg[idx] <= rx_s;
            cnt        <= 16'd0;
            if (idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // Leaving at the mid-stop sample (not at the end of the stop bit)
        // leaves half a bit of slack to catch a back-to-back start bit.
        ST_STOP: begin
          if (bit_end) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // A low line after a bad stop bit is a break, not a new start bit.
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Output register: a same-edge consume frees the slot for the new byte.
      if (accept) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. With frames driven bit-by-bit from a rising edge, the stop
// sample lands on the last rising edge of the stop bit, so the accepted byte
// is visible on the falling edge right after send_frame returns.
module tb_uart_rx;

  localparam int CPB       = 8;
  localparam int IDLE_CODE = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] fsm_state;

  logic ready_drv;
  logic rand_mode;
  logic rand_rdy;

  assign rx_ready = rand_mode ? rand_rdy : ready_drv;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         ferr_seen = 0;
  bit         mon_on    = 0;
  logic       pre_valid;
  logic       pre_ferr;
  logic [7:0] pre_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic lvl, input int n);
    rx = lvl;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rx        = 1'b1;
    ready_drv = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Drives start, 8 data bits LSB first and the stop bit. One cycle before the
  // stop sample the outputs are captured into pre_*; optionally rx_ready is
  // raised for exactly the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit ready_at_stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop, CPB - 1);
    if (ready_at_stop) ready_drv = 1'b1;
    @(negedge clk);
    pre_valid = rx_valid;
    pre_ferr  = frame_err;
    pre_data  = rx_data;
    step();
    if (ready_at_stop) ready_drv = 1'b0;
  endtask

  task automatic consume();
    ready_drv = 1'b1;
    step();
    ready_drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
    step();
  endtask

  // ---------------- random consumer and monitor ----------------
  initial begin
    rand_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected no byte", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rand_byte", rx_data, e);
          end
        end
        if (frame_err) ferr_seen++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         extra;
    int         idle_cnt;
    int         exp_ferr;
    int         gap;
    int         k;
    bit         saw_busy;
    bit         bad;
    logic [7:0] d;
    logic [7:0] f0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};

    rand_mode = 1'b0;
    ready_drv = 1'b0;
    reset     = 1'b1;
    rx        = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, IDLE_CODE);

    // Single frames with rx_ready low, each from reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      check("vec_pre_valid", pre_valid, 0);
      check("vec_pre_ferr", pre_ferr, 0);
      @(negedge clk);
      check("vec_valid", rx_valid, vecs[i].exp_valid);
      check("vec_data", rx_data, vecs[i].exp_data);
      check("vec_ferr", frame_err, vecs[i].exp_ferr);
      check("vec_overrun", overrun, 0);
      check("vec_busy", busy, vecs[i].exp_busy);
      @(negedge clk);
      check("vec_ferr_width", frame_err, 0);
      rx = 1'b1;
      wait_idle("vec_idle");
      if (vecs[i].exp_valid) begin
        check("vec_valid_held", rx_valid, 1);
        consume();
        check("vec_consumed", rx_valid, 0);
      end
    end

    // Back-to-back with rx_ready held low: second byte dropped, overrun set
    do_reset();
    send_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b0_first_data", rx_data, 8'h3C);
    check("b2b0_first_ovr", overrun, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b0_data", rx_data, 8'h3C);
    check("b2b0_valid", rx_valid, 1);
    check("b2b0_overrun", overrun, 1);
    consume();
    check("b2b0_consumed", rx_valid, 0);
    check("b2b0_overrun_sticky", overrun, 1);
    do_reset();
    @(negedge clk);
    check("b2b0_overrun_reset", overrun, 0);

    // Back-to-back with rx_ready held high: both bytes in order
    do_reset();
    ready_drv = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b1_first_valid", rx_valid, 1);
    check("b2b1_first_data", rx_data, 8'h3C);
    send_frame(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b1_second_valid", rx_valid, 1);
    check("b2b1_second_data", rx_data, 8'hC3);
    check("b2b1_overrun", overrun, 0);
    @(negedge clk);
    check("b2b1_drained", rx_valid, 0);
    ready_drv = 1'b0;

    // Bad stop bit then a long break, then a good frame
    do_reset();
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check("brk_ferr", frame_err, 1);
    check("brk_valid", rx_valid, 0);
    check("brk_busy", busy, 1);
    extra    = 0;
    idle_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_err) extra++;
      if (!busy) idle_cnt++;
    end
    check("brk_extra_ferr", extra, 0);
    check("brk_idle_while_low", idle_cnt, 0);
    check("brk_valid_after", rx_valid, 0);
    rx = 1'b1;
    wait_idle("brk_exit");
    send_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    check("brk_next_valid", rx_valid, 1);
    check("brk_next_data", rx_data, 8'h81);
    consume();

    // Two-cycle glitch on an idle line
    do_reset();
    rx = 1'b0;
    step();
    step();
    rx       = 1'b1;
    saw_busy = 1'b0;
    extra    = 0;
    k        = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (frame_err) extra++;
      if (rx_valid) k++;
    end
    check("glitch_saw_busy", saw_busy, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_ferr", extra, 0);
    check("glitch_valid", k, 0);

    // Reset during bit 4 of 0xF0, with a byte already pending
    do_reset();
    send_frame(8'hAA, 1'b1, 1'b0);
    f0 = 8'hF0;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(f0[i], CPB);
    drive_bit(f0[4], CPB / 2);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    rx    = 1'b1;
    extra = 0;
    k     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_err) extra++;
      if (rx_valid) k++;
    end
    check("midrst_no_ferr", extra, 0);
    check("midrst_no_valid", k, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    check("midrst_next_valid", rx_valid, 1);
    check("midrst_next_data", rx_data, 8'h0F);
    consume();

    // Consume 0x11 on the same edge 0x12 is accepted
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1);
    check("same_pre_valid", pre_valid, 1);
    check("same_pre_data", pre_data, 8'h11);
    @(negedge clk);
    check("same_data", rx_data, 8'h12);
    check("same_valid", rx_valid, 1);
    check("same_overrun", overrun, 0);
    consume();
    check("same_consumed", rx_valid, 0);

    // Random frames, random gaps, random consumer, occasional bad stop bit
    do_reset();
    exp_q.delete();
    ferr_seen = 0;
    exp_ferr  = 0;
    mon_on    = 1'b1;
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      if (bad) exp_ferr++;
      else exp_q.push_back(d);
      send_frame(d, !bad, 1'b0);
      gap = $urandom_range(0, 12);
      if (bad) gap += 4;
      rx = 1'b1;
      repeat (gap) step();
    end
    rx = 1'b1;
    k  = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    repeat (3) step();
    check("rand_drain", exp_q.size(), 0);
    check("rand_ferr_count", ferr_seen, exp_ferr);
    check("rand_overrun", overrun, 0);
    mon_on    = 1'b0;
    rand_mode = 1'b0;

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
